// File: rtl/host_bus_master.sv
// host_bus_master: turns single host commands into one write (AW then W) or
// read (AR then R) transaction on a valid/ready bus, with a per-phase
// timeout and a held response to the host.
module host_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        AWVALID,
    output logic [31:0] AWADDR,
    input  logic        AWREADY,
    output logic        WDVALID,
    output logic [31:0] WDATA,
    input  logic        WDREADY,
    output logic        ARVALID,
    output logic [31:0] ARADDR,
    input  logic        ARREADY,
    output logic        RDREADY,
    input  logic        RDVALID,
    input  logic [31:0] RDATA,
    output logic        busy
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 32;
    // Counter value on the last waiting edge allowed before giving up.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_AR,
        S_R,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    tmo_cnt_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                cmd_ready_q;
    logic                resp_valid_q;
    logic [WORD_W-1:0]   resp_rdata_q;
    logic                resp_err_q;
    logic                awvalid_q;
    logic [WORD_W-1:0]   awaddr_q;
    logic                wdvalid_q;
    logic [WORD_W-1:0]   wdata_out_q;
    logic                arvalid_q;
    logic [WORD_W-1:0]   araddr_q;
    logic                rdready_q;
    logic                busy_q;
    logic                timeout_hit;

    // A wait phase expires on the edge where the counter reaches its last value.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

    assign cmd_ready  = cmd_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign AWVALID    = awvalid_q;
    assign AWADDR     = awaddr_q;
    assign WDVALID    = wdvalid_q;
    assign WDATA      = wdata_out_q;
    assign ARVALID    = arvalid_q;
    assign ARADDR     = araddr_q;
    assign RDREADY    = rdready_q;
    assign busy       = busy_q;

    // Transaction FSM; every output is a register updated with its state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tmo_cnt_q    <= '0;
            wdata_q      <= '0;
            cmd_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            wdvalid_q    <= 1'b0;
            wdata_out_q  <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            rdready_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        wdata_q     <= cmd_wdata;
                        tmo_cnt_q   <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_write) begin
                            state_q   <= S_AW;
                            awvalid_q <= 1'b1;
                            awaddr_q  <= cmd_addr;
                        end else begin
                            state_q   <= S_AR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= cmd_addr;
                        end
                    end
                end
                S_AW: begin
                    if (AWREADY) begin
                        awvalid_q   <= 1'b0;
                        awaddr_q    <= '0;
                        wdvalid_q   <= 1'b1;
                        wdata_out_q <= wdata_q;
                        tmo_cnt_q   <= '0;
                        state_q     <= S_W;
                    end else if (timeout_hit) begin
                        awvalid_q    <= 1'b0;
                        awaddr_q     <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                S_W: begin
                    if (WDREADY || timeout_hit) begin
                        wdvalid_q    <= 1'b0;
                        wdata_out_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= !WDREADY;
                        resp_rdata_q <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                S_AR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        araddr_q  <= '0;
                        rdready_q <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= S_R;
                    end else if (timeout_hit) begin
                        arvalid_q    <= 1'b0;
                        araddr_q     <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                S_R: begin
                    if (RDVALID || timeout_hit) begin
                        rdready_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= !RDVALID;
                        resp_rdata_q <= RDVALID ? RDATA : '0;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        busy_q       <= 1'b0;
                        cmd_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_bus_master.sv
// Bench for host_bus_master: two instances (default and short timeout) share
// stimulus; only the selected one receives commands. Each transaction is
// summarised as phase lengths plus response and compared to an abstract model.
module tb_host_bus_master;

    localparam int unsigned T_A = 16;
    localparam int unsigned T_B = 4;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_write, resp_ready;
    logic        AWREADY, WDREADY, ARREADY, RDVALID;
    logic [31:0] cmd_addr, cmd_wdata, RDATA;
    bit          sel;

    logic        a_cmd_ready, a_resp_valid, a_resp_err, a_awvalid, a_wdvalid, a_arvalid, a_rdready, a_busy;
    logic [31:0] a_resp_rdata, a_awaddr, a_wdata, a_araddr;
    logic        b_cmd_ready, b_resp_valid, b_resp_err, b_awvalid, b_wdvalid, b_arvalid, b_rdready, b_busy;
    logic [31:0] b_resp_rdata, b_awaddr, b_wdata, b_araddr;
    logic        o_cmd_ready, o_resp_valid, o_resp_err, o_awvalid, o_wdvalid, o_arvalid, o_rdready, o_busy;
    logic [31:0] o_resp_rdata, o_awaddr, o_wdata, o_araddr;

    typedef struct packed {
        logic [15:0] aw;
        logic [15:0] w;
        logic [15:0] ar;
        logic [15:0] r;
        logic [15:0] resp;
        logic [15:0] busy;
        logic        err;
        logic [31:0] rdata;
    } obs_t;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    host_bus_master #(.TIMEOUT_CYCLES(T_A)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(a_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .AWVALID(a_awvalid), .AWADDR(a_awaddr), .AWREADY(AWREADY),
        .WDVALID(a_wdvalid), .WDATA(a_wdata), .WDREADY(WDREADY),
        .ARVALID(a_arvalid), .ARADDR(a_araddr), .ARREADY(ARREADY),
        .RDREADY(a_rdready), .RDVALID(RDVALID), .RDATA(RDATA), .busy(a_busy)
    );

    host_bus_master #(.TIMEOUT_CYCLES(T_B)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel), .cmd_ready(b_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .AWVALID(b_awvalid), .AWADDR(b_awaddr), .AWREADY(AWREADY),
        .WDVALID(b_wdvalid), .WDATA(b_wdata), .WDREADY(WDREADY),
        .ARVALID(b_arvalid), .ARADDR(b_araddr), .ARREADY(ARREADY),
        .RDREADY(b_rdready), .RDVALID(RDVALID), .RDATA(RDATA), .busy(b_busy)
    );

    assign o_cmd_ready  = sel ? b_cmd_ready  : a_cmd_ready;
    assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign o_resp_err   = sel ? b_resp_err   : a_resp_err;
    assign o_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
    assign o_awvalid    = sel ? b_awvalid    : a_awvalid;
    assign o_awaddr     = sel ? b_awaddr     : a_awaddr;
    assign o_wdvalid    = sel ? b_wdvalid    : a_wdvalid;
    assign o_wdata      = sel ? b_wdata      : a_wdata;
    assign o_arvalid    = sel ? b_arvalid    : a_arvalid;
    assign o_araddr     = sel ? b_araddr     : a_araddr;
    assign o_rdready    = sel ? b_rdready    : a_rdready;
    assign o_busy       = sel ? b_busy       : a_busy;

    // Abstract model: a phase whose partner waits d cycles lasts d+1 cycles,
    // unless d reaches the timeout t, in which case it lasts t and errors out.
    function automatic obs_t model(input int unsigned t, input bit wr, input int unsigned da,
                                   input int unsigned dw, input int unsigned dar, input int unsigned dr,
                                   input int unsigned dresp, input logic [31:0] rdval);
        obs_t e;
        bit   to1, to2;
        e = '0;
        to1 = (t != 0) && ((wr ? da : dar) >= t);
        to2 = (t != 0) && ((wr ? dw : dr) >= t);
        if (wr) begin
            e.aw = 16'(to1 ? t : da + 1);
            if (!to1) e.w = 16'(to2 ? t : dw + 1);
        end else begin
            e.ar = 16'(to1 ? t : dar + 1);
            if (!to1) e.r = 16'(to2 ? t : dr + 1);
        end
        e.err   = to1 || to2;
        e.rdata = (wr || e.err) ? 32'h0 : rdval;
        e.resp  = 16'(dresp + 1);
        e.busy  = e.aw + e.w + e.ar + e.r + e.resp;
        return e;
    endfunction

    function automatic string fmt(input obs_t x);
        return $sformatf("aw=%0d w=%0d ar=%0d r=%0d resp=%0d busy=%0d err=%0d rdata=%h",
                         x.aw, x.w, x.ar, x.r, x.resp, x.busy, x.err, x.rdata);
    endfunction

    function automatic int unsigned rnd_delay(input int unsigned t);
        return ($urandom_range(0, 3) == 0) ? $urandom_range(0, t + 2) : $urandom_range(0, 3);
    endfunction

    // Issue one command, play the bus slave with the given delays, and record
    // what the selected DUT did; protocol breaches are tallied in viol/vmsg.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdval, input int unsigned da, input int unsigned dw,
                           input int unsigned dar, input int unsigned dr, input int unsigned dresp,
                           output obs_t o, output int viol, output string vmsg);
        logic        err0;
        logic [31:0] rd0;
        bit          seen, done;
        string       w;
        o = '0; viol = 0; vmsg = ""; seen = 0; done = 0; err0 = 0; rd0 = '0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(posedge clk); #1;
            w = "";
            if (seen && !o_resp_valid) begin
                done = 1;
                if ({o_awvalid, o_wdvalid, o_arvalid, o_rdready, o_resp_err, o_busy} !== 6'b0 ||
                    o_cmd_ready !== 1'b1 || o_resp_rdata !== 32'h0 || o_awaddr !== 32'h0 ||
                    o_wdata !== 32'h0 || o_araddr !== 32'h0)
                    w = "outputs not idle after response handshake";
            end else begin
                if (o_awvalid)    o.aw   = o.aw + 16'd1;
                if (o_wdvalid)    o.w    = o.w + 16'd1;
                if (o_arvalid)    o.ar   = o.ar + 16'd1;
                if (o_rdready)    o.r    = o.r + 16'd1;
                if (o_resp_valid) o.resp = o.resp + 16'd1;
                if (o_busy)       o.busy = o.busy + 16'd1;
                if (o_resp_valid) begin
                    if (!seen) begin
                        seen = 1; err0 = o_resp_err; rd0 = o_resp_rdata;
                        o.err = o_resp_err; o.rdata = o_resp_rdata;
                    end else if (o_resp_err !== err0 || o_resp_rdata !== rd0) begin
                        w = "response changed while waiting for resp_ready";
                    end
                end
                if (o_awvalid && o_wdvalid) w = "AWVALID and WDVALID overlap";
                if (o_awaddr !== (o_awvalid ? addr : 32'h0)) w = $sformatf("AWADDR=%h", o_awaddr);
                if (o_wdata !== (o_wdvalid ? wd : 32'h0))    w = $sformatf("WDATA=%h", o_wdata);
                if (o_araddr !== (o_arvalid ? addr : 32'h0)) w = $sformatf("ARADDR=%h", o_araddr);
                if ($countones({o_awvalid, o_wdvalid, o_arvalid, o_rdready, o_resp_valid}) != 1)
                    w = "not exactly one phase signal active";
                if (o_cmd_ready !== 1'b0 || o_busy !== 1'b1) w = "cmd_ready/busy wrong while active";
            end
            if (w != "") begin
                viol++;
                if (vmsg == "") vmsg = $sformatf("cycle %0d: %s", cyc, w);
            end
            if (done) begin
                cmd_valid = 1'b0;
            end else begin
                // Junk commands while busy must be refused; junk readies must be ignored.
                cmd_valid  = o_resp_valid ? 1'b1 : 1'($urandom_range(0, 1));
                cmd_write  = 1'($urandom_range(0, 1));
                cmd_addr   = $urandom;
                cmd_wdata  = $urandom;
                AWREADY    = o_awvalid ? (o.aw > da) : 1'($urandom_range(0, 1));
                WDREADY    = o_wdvalid ? (o.w > dw) : 1'($urandom_range(0, 1));
                ARREADY    = o_arvalid ? (o.ar > dar) : 1'($urandom_range(0, 1));
                RDVALID    = o_rdready ? (o.r > dr) : 1'($urandom_range(0, 1));
                RDATA      = (o_rdready && o.r > dr) ? rdval : $urandom;
                resp_ready = o_resp_valid ? (o.resp > dresp) : 1'($urandom_range(0, 1));
            end
        end
        if (!done) begin
            viol++;
            if (vmsg == "") vmsg = "no completed response within cycle budget";
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [135:0] snap;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #0;
            snap = {o_cmd_ready, o_resp_valid, o_resp_err, o_awvalid, o_wdvalid, o_arvalid, o_rdready,
                    o_busy, o_resp_rdata, o_awaddr, o_wdata, o_araddr};
            total++;
            if (snap !== {1'b1, 135'b0}) begin
                bad++;
                $display("FAIL reset_state dut%0d: got %h required %h", s, snap, {1'b1, 135'b0});
            end
        end
        rst = 1'b0;
        sel = 0;
    endtask

    task automatic test_write_basic();
        obs_t o, e; int v; string m;
        sel = 0;
        run_txn(1'b1, 32'h8, 32'h5678, 32'h0, 0, 0, 0, 0, 0, o, v, m);
        e = model(T_A, 1'b1, 0, 0, 0, 0, 0, 32'h0);
        total++;
        if (o !== e) begin bad++; $display("FAIL write_basic: got %s required %s", fmt(o), fmt(e)); end
        total++;
        if (v !== 0) begin bad++; $display("FAIL write_basic protocol: %0d breaches (%s) required 0", v, m); end
    endtask

    task automatic test_read_basic();
        obs_t o, e; int v; string m;
        sel = 0;
        run_txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0, 3, 0, o, v, m);
        e = model(T_A, 1'b0, 0, 0, 0, 3, 0, 32'hDEADBEEF);
        total++;
        if (o !== e) begin bad++; $display("FAIL read_basic: got %s required %s", fmt(o), fmt(e)); end
        total++;
        if (v !== 0) begin bad++; $display("FAIL read_basic protocol: %0d breaches (%s) required 0", v, m); end
    endtask

    task automatic test_aw_backpressure();
        obs_t o, e; int v; string m;
        sel = 0;
        run_txn(1'b1, 32'hA000_0040, 32'h1234_ABCD, 32'h0, 5, 2, 0, 0, 0, o, v, m);
        e = model(T_A, 1'b1, 5, 2, 0, 0, 0, 32'h0);
        total++;
        if (o !== e) begin bad++; $display("FAIL aw_backpressure: got %s required %s", fmt(o), fmt(e)); end
        total++;
        if (v !== 0) begin bad++; $display("FAIL aw_backpressure protocol: %0d breaches (%s) required 0", v, m); end
    endtask

    task automatic test_timeout();
        obs_t o, e; int v; string m;
        sel = 1;
        run_txn(1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 0, 1000, 0, 0, o, v, m);
        e = model(T_B, 1'b0, 0, 0, 1000, 0, 0, 32'hCAFE_F00D);
        total++;
        if (o !== e) begin bad++; $display("FAIL timeout_ar: got %s required %s", fmt(o), fmt(e)); end
        total++;
        if (v !== 0) begin bad++; $display("FAIL timeout_ar protocol: %0d breaches (%s) required 0", v, m); end
        sel = 0;
    endtask

    // Handshake on the expiring edge wins; one cycle later it is an error.
    task automatic test_timeout_boundary();
        obs_t o, e; int v; string m;
        int unsigned d1, d2;
        sel = 1;
        for (int k = 0; k < 8; k++) begin
            d1 = (k[1] == 1'b0) ? T_B - 1 + int'(k[2]) : 0;
            d2 = (k[1] == 1'b1) ? T_B - 1 + int'(k[2]) : 1;
            run_txn(k[0], 32'h100 + 32'(k), 32'h5A5A_0000 + 32'(k), 32'h7700_0000 + 32'(k),
                    d1, d2, d1, d2, 0, o, v, m);
            e = model(T_B, k[0], d1, d2, d1, d2, 0, 32'h7700_0000 + 32'(k));
            total++;
            if (o !== e) begin bad++; $display("FAIL timeout_boundary case %0d: got %s required %s", k, fmt(o), fmt(e)); end
            total++;
            if (v !== 0) begin bad++; $display("FAIL timeout_boundary case %0d protocol: %0d breaches (%s) required 0", k, v, m); end
        end
        sel = 0;
    endtask

    task automatic test_resp_backpressure();
        obs_t o, e; int v; string m;
        sel = 0;
        run_txn(1'b0, 32'h30, 32'h0, 32'h0BAD_F00D, 1, 1, 1, 1, 3, o, v, m);
        e = model(T_A, 1'b0, 1, 1, 1, 1, 3, 32'h0BAD_F00D);
        total++;
        if (o !== e) begin bad++; $display("FAIL resp_backpressure: got %s required %s", fmt(o), fmt(e)); end
        total++;
        if (v !== 0) begin bad++; $display("FAIL resp_backpressure protocol: %0d breaches (%s) required 0", v, m); end
    endtask

    task automatic test_reset_abort();
        obs_t o, e; int v; string m; int rv;
        sel = 0; AWREADY = 1'b1; WDREADY = 1'b0; resp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h99;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (o_wdvalid !== 1'b1 || o_wdata !== 32'h99) begin
            bad++; $display("FAIL reset_abort setup: WDVALID=%b WDATA=%h required 1 00000099", o_wdvalid, o_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({o_wdvalid, o_cmd_ready, o_resp_valid, o_busy, o_wdata} !== {4'b0100, 32'h0}) begin
            bad++;
            $display("FAIL reset_abort state: WDVALID=%b cmd_ready=%b resp_valid=%b busy=%b WDATA=%h required 0 1 0 0 0",
                     o_wdvalid, o_cmd_ready, o_resp_valid, o_busy, o_wdata);
        end
        rv = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (o_resp_valid) rv++;
        end
        total++;
        if (rv !== 0) begin bad++; $display("FAIL reset_abort stray response: %0d cycles required 0", rv); end
        run_txn(1'b1, 32'h48, 32'h1111_2222, 32'h0, 1, 1, 0, 0, 1, o, v, m);
        e = model(T_A, 1'b1, 1, 1, 0, 0, 1, 32'h0);
        total++;
        if (o !== e) begin bad++; $display("FAIL reset_abort follow-up: got %s required %s", fmt(o), fmt(e)); end
        total++;
        if (v !== 0) begin bad++; $display("FAIL reset_abort follow-up protocol: %0d breaches (%s) required 0", v, m); end
    endtask

    // Random commands issued with no idle gap between them, on either instance.
    task automatic test_back_to_back();
        obs_t o, e; int v; string m;
        bit wr; int unsigned t, da, dw, dar, dr, dresp;
        logic [31:0] addr, wd, rdval;
        for (int n = 0; n < 40; n++) begin
            sel   = bit'($urandom_range(0, 1));
            t     = sel ? T_B : T_A;
            wr    = 1'($urandom_range(0, 1));
            addr  = $urandom; wd = $urandom; rdval = $urandom;
            da    = rnd_delay(t); dw = rnd_delay(t); dar = rnd_delay(t); dr = rnd_delay(t);
            dresp = $urandom_range(0, 3);
            run_txn(wr, addr, wd, rdval, da, dw, dar, dr, dresp, o, v, m);
            e = model(t, wr, da, dw, dar, dr, dresp, rdval);
            total++;
            if (o !== e) begin bad++; $display("FAIL random txn %0d: got %s required %s", n, fmt(o), fmt(e)); end
            total++;
            if (v !== 0) begin bad++; $display("FAIL random txn %0d protocol: %0d breaches (%s) required 0", n, v, m); end
        end
        sel = 0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        resp_ready = 1'b0; AWREADY = 1'b0; WDREADY = 1'b0; ARREADY = 1'b0; RDVALID = 1'b0;
        RDATA = '0; sel = 0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_aw_backpressure();
        test_timeout();
        test_timeout_boundary();
        test_resp_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
